// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
// Shares one RS232 transmit path (a serializer with its own TX FIFO) among
// NUM_REQ byte-stream sources. Ownership is granted round-robin, one whole
// message at a time, so messages from different sources never interleave on
// the wire. Writes are throttled by the serializer's registered free-space
// count. A granted source that stalls mid-message for MAX_IDLE_GAP cycles
// loses its grant.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   src_valid         per-source byte valid
//   src_data          per-source byte, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_last          per-source end-of-message flag
//   src_ready         byte accepted this cycle (combinational, one-hot or zero)
//   fifo_write_space  free TX FIFO entries reported by the serializer
//   transmit_data     byte to the serializer
//   transmit_data_en  one-cycle write strobe to the serializer
//   grant             one-hot owner of the transmit path, 0 when idle
//   busy              a message is in progress
//   abort_pulse       one-cycle pulse when a grant is revoked by the gap timeout
//
// state | meaning
// IDLE  | no owner, waiting for any src_valid
// ARB   | pick next requester round-robin from the pointer
// SEND  | forward the owner's bytes until last byte or gap timeout
module rs232_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int SPACE_MARGIN = 3,
  parameter int MAX_IDLE_GAP = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              src_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   src_data,
  input  logic [NUM_REQ-1:0]              src_last,
  output logic [NUM_REQ-1:0]              src_ready,
  input  logic [7:0]                      fifo_write_space,
  output logic [DATA_WIDTH-1:0]           transmit_data,
  output logic                            transmit_data_en,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic                            abort_pulse
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       gidx;
  logic [7:0]             gap_cnt;

  logic                   space_ok;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_last;
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       next_ptr;

  // The space count lags the FIFO by a cycle or two, hence the margin.
  assign space_ok = fifo_write_space > 8'(SPACE_MARGIN);
  assign accept   = (state == SEND) && src_valid[gidx] && space_ok;
  assign sel_data = src_data[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = src_last[gidx];
  assign next_ptr = IDX_W'((int'(gidx) + 1) % NUM_REQ);

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[gidx] = 1'b1;
  end

  // Walk from the farthest candidate back to the pointer so the last hit
  // is the first requester at or after the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (src_valid[(int'(ptr) + k) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      gidx             <= '0;
      gap_cnt          <= '0;
      grant            <= '0;
      busy             <= 1'b0;
      transmit_data    <= '0;
      transmit_data_en <= 1'b0;
      abort_pulse      <= 1'b0;
    end else begin
      transmit_data_en <= 1'b0;
      abort_pulse      <= 1'b0;
      case (state)
        IDLE: begin
          if (|src_valid) state <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            gidx    <= arb_idx;
            grant   <= ONE_HOT0 << arb_idx;
            busy    <= 1'b1;
            gap_cnt <= '0;
            state   <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (accept) begin
            transmit_data    <= sel_data;
            transmit_data_en <= 1'b1;
            gap_cnt          <= '0;
            if (sel_last) begin
              ptr   <= next_ptr;
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (!src_valid[gidx]) begin
            // Stalls on FIFO space keep the grant; only a silent source ages out.
            if (gap_cnt == 8'(MAX_IDLE_GAP - 1)) begin
              abort_pulse <= 1'b1;
              ptr         <= next_ptr;
              grant       <= '0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rs232_tx_arbiter.md
Name: rs232_tx_arbiter

Overview:
- Shares the single RS232 transmit path (serializer with 128-deep TX FIFO) among NUM_REQ independent byte-stream sources.
- Grants are round-robin per message: once a source is granted, all its bytes up to and including the one flagged last are written contiguously into the TX FIFO, so messages never interleave on the wire.
- Throttles writes using the serializer's registered fifo_write_space count.
- Sits between the on-chip message producers and the serializer's transmit_data/transmit_data_en inputs.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- DATA_WIDTH, 8, byte width; must equal the serializer DATA_WIDTH.
- SPACE_MARGIN, 3, writes are permitted only while fifo_write_space > SPACE_MARGIN; this covers the lag of the registered space count.
- MAX_IDLE_GAP, 255, cycles a granted source may stall with src_valid low mid-message before the grant is revoked (8-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src_valid  in  NUM_REQ  per-source byte valid
- src_data  in  NUM_REQ*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_last  in  NUM_REQ  byte is the final byte of its message
- src_ready  out  NUM_REQ  byte accepted this cycle (combinational, one-hot or zero)
- fifo_write_space  in  8  free entries in the TX FIFO, 0..128
- transmit_data  out  DATA_WIDTH  byte to the serializer
- transmit_data_en  out  1  one-cycle write strobe to the serializer
- grant  out  NUM_REQ  one-hot owner of the transmit path, 0 when idle
- busy  out  1  a message is in progress
- abort_pulse  out  1  one-cycle pulse when a grant is revoked by the gap timeout

Behaviour:
- Reset values:
  - transmit_data_en=0, transmit_data=0, grant=0, busy=0, abort_pulse=0, src_ready=0.
  - Round-robin pointer = 0, gap counter = 0, FSM = IDLE.
- FSM states: IDLE, ARB, SEND.
- IDLE:
  - If any src_valid bit is high, go to ARB next cycle; otherwise stay.
  - src_ready=0.
- ARB:
  - Select the first source with src_valid high, searching from pointer upward with wrap at NUM_REQ-1 -> 0.
  - Register the result into grant, set busy=1, go to SEND.
  - If no src_valid bit is still high, return to IDLE.
  - No byte is accepted in ARB.
- SEND, with g the granted index:
  - A byte is accepted when src_valid[g] & (fifo_write_space > SPACE_MARGIN); src_ready[g] = that condition, and all other src_ready bits = 0.
  - On acceptance, next cycle transmit_data = src_data[g] and transmit_data_en = 1. Latency from accept to strobe is exactly 1 cycle. Back-to-back bytes give back-to-back strobes.
  - If the accepted byte has src_last[g]=1: go to IDLE, clear grant and busy, and set pointer = (g+1) mod NUM_REQ.
  - Gap counter: reset on every acceptance; increments each SEND cycle with src_valid[g] low.
  - When the gap counter reaches MAX_IDLE_GAP: pulse abort_pulse, go to IDLE, set pointer = (g+1) mod NUM_REQ, clear grant and busy. The serializer sends the partial message as-is.
  - Cycles stalled on space (src_valid[g]=1, space too low) do not advance the gap counter.
- transmit_data_en is 0 in every cycle not following an acceptance; transmit_data holds its last value.
- Arbitration is strictly message-granular:
  - src_valid from other sources during SEND has no effect.
  - A source holding src_valid continuously is served at most once before every other active requester is served.
- fifo_write_space = 0 or <= SPACE_MARGIN: no acceptances; grant is held indefinitely.
- Single-byte message (src_valid and src_last high together): sequence IDLE->ARB->SEND->IDLE, with one strobe.
- Reset asserted mid-message: all state returns to reset values on that edge. A partially sent message is not resumed, and the source must restart its message.

Test Plan:
- Single source 0, 3-byte message 0x41,0x42,0x43 (last on 0x43), fifo_write_space=128 -> three consecutive transmit_data_en strobes carrying 0x41,0x42,0x43; the first strobe comes 3 cycles after src_valid rises; then grant=0, busy=0.
- Sources 1 and 2 both request 2-byte messages simultaneously with pointer=0 -> all of source 1's bytes are strobed, then all of source 2's, with no interleave; pointer ends at 3.
- Source 0 holds src_valid continuously (repeated 1-byte messages) while source 3 requests once -> the grant order includes 3 immediately after the first source-0 message.
- fifo_write_space=3 during SEND -> src_ready=0, no strobes, grant held; raise to 4 -> acceptance resumes in the same cycle.
- Granted source drops src_valid mid-message for MAX_IDLE_GAP cycles -> one abort_pulse, grant=0, and the next requester is served.
- Reset asserted between the 2nd and 3rd bytes of a message -> all outputs return to 0 the following cycle; no further strobes until a new request.
